// File: rtl/mul_sequencer.sv
// Operand FIFO, issue FSM and one-entry result slot in front of a sequential multiplier.
// Pairs are popped one at a time; each product is held until the consumer acknowledges it.
module mul_sequencer #(
  parameter int unsigned x     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [x-1:0]             in_a,
  input  logic [x-1:0]             in_b,
  output logic                     start,
  output logic [x-1:0]             OpA,
  output logic [x-1:0]             OpB,
  input  logic                     busy,
  input  logic                     ready,
  input  logic [2*x-1:0]           mul,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic [2*x-1:0]           res,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [x-1:0]    r_mem_a [DEPTH];
  logic [x-1:0]    r_mem_b [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_start;
  logic [x-1:0]    r_opa;
  logic [x-1:0]    r_opb;
  logic [2*x-1:0]  r_res;
  logic            r_res_valid;

  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_start_nxt;
  logic            w_slot_free;
  logic            w_fifo_nonempty;

  // A full FIFO never refills in the cycle it is popped.
  assign in_ready        = (r_level != LW'(DEPTH)) && reset;
  assign w_push          = in_valid && in_ready;
  assign w_slot_free     = !r_res_valid || res_ack;
  assign w_fifo_nonempty = (r_level != '0);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ARM waits for busy so a ready left over from the previous operation is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fifo_nonempty && w_slot_free) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_ARM;
      S_ARM:   if (busy) w_state_nxt = S_WAIT;
      S_WAIT:  if (ready && !busy) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop       = 1'b0;
    w_start_nxt = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop       = w_fifo_nonempty && w_slot_free;
        w_start_nxt = w_fifo_nonempty && w_slot_free;
      end
      S_WAIT:  w_capture = ready && !busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_start     <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_start <= w_start_nxt;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_opa    <= r_mem_a[r_rd_ptr];
        r_opb    <= r_mem_b[r_rd_ptr];
      end
      // Capture and ack never coincide: issue needs the slot free first.
      if (w_capture) begin
        r_res       <= mul;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ack) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign start     = r_start;
  assign OpA       = r_opa;
  assign OpB       = r_opb;
  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign level     = r_level;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural stub multiplier.
// Stub: after start, busy rises busy_delay cycles later, stays 3 cycles, then ready+product.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        start;
  logic [7:0]  OpA;
  logic [7:0]  OpB;
  logic        busy;
  logic        ready;
  logic [15:0] mul;
  logic        res_valid;
  logic        res_ack;
  logic [15:0] res;
  logic [2:0]  level;

  int ncmp = 0;
  int nfail = 0;
  int start_cnt = 0;
  int busy_delay = 1;
  bit keep_ready = 1'b0;
  int st_phase;
  int st_cnt;

  mul_sequencer #(.x(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .OpA(OpA), .OpB(OpB),
    .busy(busy), .ready(ready), .mul(mul),
    .res_valid(res_valid), .res_ack(res_ack), .res(res), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start === 1'b1) start_cnt++;

  // Stub multiplier; shares reset with the DUT.
  always @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0; ready <= 1'b0; mul <= 16'd0; st_phase <= 0; st_cnt <= 0;
    end else begin
      case (st_phase)
        0: if (start) begin
             if (!keep_ready) ready <= 1'b0;
             st_cnt <= busy_delay; st_phase <= 1;
           end
        1: if (st_cnt <= 1) begin busy <= 1'b1; st_cnt <= 3; st_phase <= 2; end
           else st_cnt <= st_cnt - 1;
        default:
           if (st_cnt <= 1) begin
             busy <= 1'b0; ready <= 1'b1; mul <= OpA * OpB; st_phase <= 0;
           end else st_cnt <= st_cnt - 1;
      endcase
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      ncmp++; nfail++;
      $display("FAIL push_timeout: in_ready=%0b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [15:0] exp, input string nm);
    int t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    ncmp++;
    if (!res_valid) begin
      nfail++; $display("FAIL %s: res_valid=0 expected 1 (timeout)", nm);
    end else if (res !== exp) begin
      nfail++; $display("FAIL %s: res=%0d expected %0d", nm, res, exp);
    end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    ncmp++;
    if (!res_valid) begin nfail++; $display("FAIL %s: res_valid=0 expected 1 (timeout)", nm); end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; res_ack = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
    ncmp++; if (start !== 1'b0) begin nfail++; $display("FAIL rst_start: got %0b expected 0", start); end
    ncmp++; if (OpA !== 8'd0 || OpB !== 8'd0) begin nfail++; $display("FAIL rst_ops: got %0d/%0d expected 0/0", OpA, OpB); end
    ncmp++; if (res !== 16'd0 || res_valid !== 1'b0) begin nfail++; $display("FAIL rst_res: got %0d/%0b expected 0/0", res, res_valid); end
    ncmp++; if (level !== 3'd0) begin nfail++; $display("FAIL rst_level: got %0d expected 0", level); end
    reset = 1'b1;
    #1;
    ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single;
    start_cnt = 0;
    in_a = 8'd13; in_b = 8'd11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ncmp++; if (level !== 3'd1 || start !== 1'b0) begin nfail++; $display("FAIL single_push: level=%0d start=%0b expected 1/0", level, start); end
    @(negedge clk);
    ncmp++; if (level !== 3'd0 || start !== 1'b1) begin nfail++; $display("FAIL single_pop: level=%0d start=%0b expected 0/1", level, start); end
    ncmp++; if (OpA !== 8'd13 || OpB !== 8'd11) begin nfail++; $display("FAIL single_ops: got %0d/%0d expected 13/11", OpA, OpB); end
    @(negedge clk);
    ncmp++; if (start !== 1'b0) begin nfail++; $display("FAIL single_pulse: start=%0b expected 0", start); end
    wait_result(16'd143, "single_res");
    ncmp++; if (res_valid !== 1'b0 || level !== 3'd0) begin nfail++; $display("FAIL single_ack: res_valid=%0b level=%0d expected 0/0", res_valid, level); end
    ncmp++; if (start_cnt !== 1) begin nfail++; $display("FAIL single_starts: got %0d expected 1", start_cnt); end
  endtask

  task automatic test_max;
    push(8'd255, 8'd255);
    wait_result(16'd65025, "max_255x255");
  endtask

  task automatic test_fill;
    push(8'd0, 8'd200);
    wait_valid("fill_blocker");
    for (int i = 1; i <= 4; i++) push(8'(i), 8'(i));
    ncmp++; if (level !== 3'd4 || in_ready !== 1'b0) begin nfail++; $display("FAIL fill_full: level=%0d in_ready=%0b expected 4/0", level, in_ready); end
    in_a = 8'd5; in_b = 8'd5; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    ncmp++; if (level !== 3'd4 || in_ready !== 1'b0) begin nfail++; $display("FAIL fill_stall: level=%0d in_ready=%0b expected 4/0", level, in_ready); end
    ncmp++; if (res !== 16'd0 || res_valid !== 1'b1) begin nfail++; $display("FAIL max_0x200: res=%0d valid=%0b expected 0/1", res, res_valid); end
    res_ack = 1'b1;
    #1;
    ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL fill_no_refill: in_ready=%0b expected 0", in_ready); end
    @(negedge clk);
    res_ack = 1'b0;
    ncmp++; if (level !== 3'd3) begin nfail++; $display("FAIL fill_after_pop: level=%0d expected 3", level); end
    @(negedge clk);
    in_valid = 1'b0;
    ncmp++; if (level !== 3'd4) begin nfail++; $display("FAIL fill_fifth: level=%0d expected 4", level); end
    wait_result(16'd1,  "fill_r1");
    wait_result(16'd4,  "fill_r2");
    wait_result(16'd9,  "fill_r3");
    wait_result(16'd16, "fill_r4");
    wait_result(16'd25, "fill_r5");
  endtask

  task automatic test_stale_ready;
    bit saw_busy = 1'b0;
    int t = 0;
    keep_ready = 1'b1; busy_delay = 3;
    push(8'd7, 8'd6);
    while (!res_valid && t < 200) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk); t++;
    end
    ncmp++; if (saw_busy !== 1'b1) begin nfail++; $display("FAIL stale_early: busy_seen=%0b expected 1", saw_busy); end
    ncmp++; if (res !== 16'd42 || res_valid !== 1'b1) begin nfail++; $display("FAIL stale_res: res=%0d valid=%0b expected 42/1", res, res_valid); end
    res_ack = 1'b1; @(negedge clk); res_ack = 1'b0;
    keep_ready = 1'b0; busy_delay = 1;
  endtask

  task automatic test_reset_mid;
    int t = 0;
    int saved;
    push(8'd3, 8'd3); push(8'd4, 8'd4); push(8'd5, 8'd5);
    while (!busy && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    ncmp++; if (level !== 3'd2) begin nfail++; $display("FAIL rmid_queued: level=%0d expected 2", level); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    ncmp++; if (level !== 3'd0 || res_valid !== 1'b0 || start !== 1'b0) begin nfail++; $display("FAIL rmid_clear: level=%0d valid=%0b start=%0b expected 0/0/0", level, res_valid, start); end
    ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rmid_ready: got %0b expected 1", in_ready); end
    saved = start_cnt;
    repeat (20) @(negedge clk);
    ncmp++; if (start_cnt !== saved || res_valid !== 1'b0) begin nfail++; $display("FAIL rmid_quiet: starts=%0d valid=%0b expected %0d/0", start_cnt, res_valid, saved); end
    push(8'd9, 8'd9);
    wait_result(16'd81, "rmid_recover");
  endtask

  task automatic test_back_to_back;
    push(8'd2, 8'd3);
    wait_valid("b2b_first");
    push(8'd4, 8'd5); push(8'd6, 8'd7);
    ncmp++; if (level !== 3'd2) begin nfail++; $display("FAIL b2b_level_pre: level=%0d expected 2", level); end
    ncmp++; if (res !== 16'd6) begin nfail++; $display("FAIL b2b_r0: res=%0d expected 6", res); end
    in_a = 8'd8; in_b = 8'd9; in_valid = 1'b1; res_ack = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; res_ack = 1'b0;
    ncmp++; if (level !== 3'd2) begin nfail++; $display("FAIL b2b_pushpop: level=%0d expected 2", level); end
    ncmp++; if (start !== 1'b1 || OpA !== 8'd4 || OpB !== 8'd5) begin nfail++; $display("FAIL b2b_issue: start=%0b ops=%0d/%0d expected 1 4/5", start, OpA, OpB); end
    wait_result(16'd20, "b2b_r1");
    wait_result(16'd42, "b2b_r2");
    wait_result(16'd72, "b2b_r3");
  endtask

  task automatic test_wrap;
    logic [7:0]  ta [10] = '{8'd3, 8'd17, 8'd100, 8'd255, 8'd0, 8'd128, 8'd64, 8'd200, 8'd31, 8'd250};
    logic [7:0]  tb [10] = '{8'd7, 8'd3, 8'd2, 8'd2, 8'd9, 8'd128, 8'd4, 8'd250, 8'd31, 8'd1};
    logic [15:0] te [10] = '{16'd21, 16'd51, 16'd200, 16'd510, 16'd0, 16'd16384, 16'd256, 16'd50000, 16'd961, 16'd250};
    for (int i = 0; i < 10; i++) begin
      push(ta[i], tb[i]);
      wait_result(te[i], $sformatf("wrap_%0d", i));
    end
    ncmp++; if (level !== 3'd0 || res_valid !== 1'b0) begin nfail++; $display("FAIL wrap_end: level=%0d valid=%0b expected 0/0", level, res_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_fill();
    test_stale_ready();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Operand-issue and result-capture stage wrapped around the sequential multiplier (control + datapath pair). Buffers incoming operand pairs in a small FIFO, issues them one at a time to the multiplier with a one-cycle `start` pulse, waits for completion, and holds each 2x-bit product in an output register until the consumer acknowledges it. Sits directly upstream of the multiplier's `start`/`OpA`/`OpB` inputs and directly downstream of its `busy`/`ready`/`mul` outputs.

## Interface
- `x`, 8: operand width; product width is 2*x.
- `DEPTH`, 4: operand FIFO entries; power of two, >= 2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; clears all state on the rising edge of `clk` where it is 0.
- `in_valid`  in  1  operand pair present on `in_a`/`in_b`.
- `in_ready`  out  1  FIFO can accept; push occurs when `in_valid` && `in_ready`.
- `in_a`, `in_b`  in  x  operands.
- `start`  out  1  one-cycle issue pulse to multiplier control.
- `OpA`, `OpB`  out  x  operands to multiplier datapath; stable from issue until completion.
- `busy`  in  1  multiplier busy.
- `ready`  in  1  multiplier result valid.
- `mul`  in  2*x  multiplier product.
- `res_valid`  out  1  `res` holds an unacknowledged product.
- `res_ack`  in  1  consumer accepts `res`.
- `res`  out  2*x  captured product.
- `level`  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH, occupancy counter. `in_ready` = (level != DEPTH) && `reset`. No bypass: a pushed pair is poppable the cycle after the push.
- FSM states: IDLE, ISSUE, ARM, WAIT.
  - IDLE: if level != 0 and result slot free (`res_valid`==0, or `res_valid`&&`res_ack` this cycle), pop head into `OpA`/`OpB`, go ISSUE; else stay.
  - ISSUE: `start`=1 for this cycle only; go ARM.
  - ARM: wait for `busy`==1, then go WAIT. This masks a stale `ready` left high from the previous operation.
  - WAIT: when `ready`==1 and `busy`==0, load `mul` into `res`, set `res_valid`, go IDLE.
- Result slot: one entry. `res_valid` clears on the edge where `res_ack` is sampled high with `res_valid`==1. Capture and clear never coincide, because issue requires the slot free before the operation starts.
- Push and pop in the same cycle: both take effect; level unchanged.
- When full, `in_ready` is 0 even if a pop happens that cycle (no same-cycle refill).
- `res_ack` while `res_valid`==0: ignored.
- Arithmetic: product is taken verbatim from `mul`; no truncation or sign handling here.

## Timing
- Reset values: `in_ready`=0 while `reset`==0, and 1 in the first cycle after release; `start`=0, `OpA`=0, `OpB`=0, `res`=0, `res_valid`=0, `level`=0, FSM=IDLE, pointers=0.
- Reset mid-operation (any state): FIFO emptied, in-flight operation dropped, no result produced. The multiplier shares `reset` and aborts too.
- Latency, empty FIFO and idle FSM:
  - push at edge E0;
  - pop and `OpA`/`OpB` load at E1;
  - `start` high during cycle E1..E2;
  - ARM from E2.
- Result: `res_valid` rises on the edge after the WAIT cycle in which `ready` && !`busy` is sampled.
- Back-to-back: the next pop may occur in the same edge as `res_ack`, so the next `start` follows the ack by one cycle.
- `OpA`/`OpB` change only on a pop edge.

## Test plan
- Single op (x=8): push (13, 11) after reset -> exactly one `start` pulse; `res`=143 with `res_valid`=1; after `res_ack`, `res_valid`=0 and `level`=0.
- Fill: push 5 pairs with consumer stalled (`res_ack`=0) -> `in_ready`=0 once `level`=4; 5th pair accepted only after a pop; results arrive in order (1*1, 2*2, 3*3, 4*4, 5*5 -> 1, 4, 9, 16, 25).
- Max operands: (255, 255) -> `res`=65025; (0, 200) -> `res`=0.
- Stale ready: hold `ready`=1 through ARM with a stub multiplier that raises `busy` 3 cycles late -> no capture until `busy` has risen and `ready` && !`busy` is seen.
- Reset mid-WAIT: assert `reset`=0 for 1 cycle with 2 pairs queued -> `level`=0, `res_valid`=0, no `start` until a new push.
- Simultaneous push/pop at `level`=2 -> `level` stays 2; pointer wrap exercised over 10 ops with correct products.
